// File: rtl/urv_uart_tx.sv
// uRV memory-mapped 8N1 UART transmitter with polled STATUS word.
// Define URV_UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer, else one holding register.
module urv_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
  parameter int          BAUD_DIV   = 868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        txd_o,
  output logic        busy_o
);

`ifdef URV_UART_TX_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] BAUD_LD = 16'(BAUD_DIV - 1);

  logic [1:0]    state;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [7:0]    head;
  logic [31:0]   status;
  logic          hit;
  logic          hit_txdata;
  logic          hit_status;
  logic          lane0;
  logic          full;
  logic          empty;
  logic          bit_end;
  logic          pop;
  logic          stall;
  logic          push;
  logic          idle_nxt;
  logic          unused_bits;

  assign unused_bits = ^{dm_addr_i[1:0], dm_data_s_i[31:8],
                         dm_data_select_i[3:1]};

  assign hit        = dm_addr_i[31:3] == BASE_ADDR[31:3];
  assign hit_txdata = hit && !dm_addr_i[2];
  assign hit_status = hit && dm_addr_i[2];
  assign lane0      = dm_data_select_i[0];

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign bit_end = baud_cnt == 16'd0;

  // Head leaves the buffer when idle or exactly at the end of STOP.
  assign pop = !empty &&
               ((state == S_IDLE) || (state == S_STOP && bit_end));

  assign stall           = hit_txdata && lane0 && full && !pop;
  assign dm_store_done_o = dm_store_i && !stall;
  assign push            = dm_store_i && hit_txdata && lane0 && !stall;

  assign count_nxt = count + CW'(push) - CW'(pop);
  assign idle_nxt  = !pop &&
                     ((state == S_IDLE) || (state == S_STOP && bit_end));

`ifdef URV_UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= dm_data_s_i[7:0];
  end

  assign head = mem[rd_ptr];
`else
  logic [7:0] hold;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  hold <= '0;
    else if (push) hold <= dm_data_s_i[7:0];
  end

  assign head = hold;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count  <= '0;
      busy_o <= 1'b0;
    end else begin
      count  <= count_nxt;
      busy_o <= !(idle_nxt && count_nxt == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state    <= S_START;
            baud_cnt <= BAUD_LD;
            shreg    <= head;
          end
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            baud_cnt <= BAUD_LD;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_LD;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              state    <= S_START;
              baud_cnt <= BAUD_LD;
              shreg    <= head;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    txd_o = 1'b1;
    case (state)
      S_START: txd_o = 1'b0;
      S_DATA:  txd_o = shreg[0];
      default: txd_o = 1'b1;
    endcase
  end

  assign status = {15'd0, 9'(count), 5'd0, empty, state != S_IDLE, full};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dm_data_l_o    <= '0;
      dm_load_done_o <= 1'b0;
    end else begin
      dm_load_done_o <= dm_load_i;
      dm_data_l_o    <= (dm_load_i && hit_status) ? status : '0;
    end
  end

endmodule
